// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU and its sweep driver.
//   - opcode encodings understood by the combinational ALU
//   - OP_MAX_DEFAULT : highest opcode the ALU implements
//   - sweep_state_e  : state encoding of alu_sweep_driver (IDLE must be 0 so
//                      that a cleared state register means "idle")
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;

  localparam int OP_MAX_DEFAULT = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } sweep_state_e;

endpackage

// File: rtl/alu_settle_timer.sv
// -----------------------------------------------------------------------------
// alu_settle_timer
// Loadable down-counter that tells the sweep driver when the ALU inputs have
// been stable long enough. Loading value N makes o_expire high on the N-th
// cycle after the load edge (N >= 1), so the caller stays in its wait state
// for exactly N cycles. The counter parks at zero afterwards.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : load i_value this cycle
//   i_value    : settle length in cycles
//   o_expire   : last cycle of the settle window
// -----------------------------------------------------------------------------
module alu_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/alu_sweep_driver.sv
// -----------------------------------------------------------------------------
// alu_sweep_driver
// Latches one operand pair and walks the ALU opcode bus from op_first to
// min(op_last, OP_MAX). Each opcode is held for SETTLE_CYCLES cycles, the ALU
// result is captured, and it is offered downstream on res_valid/out_ready.
// Divide/modulo by zero yields res_data = 0 with res_dz set.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   start, x_in, y_in             : sweep request and operands (IDLE only)
//   op_first, op_last             : opcode range, latched with start
//   alu_result                    : combinational ALU result
//   alu_x, alu_y, alu_op          : ALU operand/opcode bus
//   res_valid, out_ready          : result handshake
//   res_data, res_op, res_dz      : captured result, its opcode, div-by-zero
//   busy, done                    : not idle / one-cycle end-of-sweep pulse
//   checksum                      : XOR of delivered results
// Build option: define ALU_SWEEP_CHECKSUM_EN to build the checksum register;
// otherwise checksum is tied to zero.
// -----------------------------------------------------------------------------
module alu_sweep_driver
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int OP_MAX        = OP_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic [3:0] op_first,
  input  logic [3:0] op_last,
  input  logic [7:0] alu_result,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [7:0] alu_op,
  output logic       res_valid,
  input  logic       out_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_op,
  output logic       res_dz,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum
);

  localparam logic [3:0] OP_MAX_L = 4'(OP_MAX);
  localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYCLES);

  sweep_state_e r_state;
  sweep_state_e w_next;

  logic [3:0] r_x;
  logic [3:0] r_y;
  logic [3:0] r_op;
  logic [3:0] r_last;
  logic [7:0] r_res_data;
  logic [3:0] r_res_op;
  logic       r_res_dz;

  logic [3:0] w_eff_last;
  logic       w_accept;
  logic       w_empty;
  logic       w_handshake;
  logic       w_is_last;
  logic       w_dz;
  logic       w_timer_load;
  logic       w_expire;

  // Opcodes above OP_MAX are clipped rather than issued.
  assign w_eff_last  = (op_last > OP_MAX_L) ? OP_MAX_L : op_last;
  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_empty     = (op_first > w_eff_last);
  assign w_handshake = (r_state == ST_PRESENT) && out_ready;
  // Compared before any increment, so a range ending at 15 cannot wrap to 0.
  assign w_is_last   = (r_op == r_last);
  assign w_dz        = ((r_op == OP_DIV) || (r_op == OP_MOD)) && (r_y == 4'd0);

  alu_settle_timer #(
    .WIDTH (4)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_timer_load),
    .i_value  (SETTLE_L),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next       = w_empty ? ST_FINISH : ST_ISSUE;
          w_timer_load = !w_empty;
        end
      end
      ST_ISSUE: begin
        if (w_expire) begin
          w_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (w_is_last) begin
            w_next = ST_FINISH;
          end else begin
            w_next       = ST_ISSUE;
            w_timer_load = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= 4'd0;
      r_y        <= 4'd0;
      r_op       <= 4'd0;
      r_last     <= 4'd0;
      r_res_data <= 8'd0;
      r_res_op   <= 4'd0;
      r_res_dz   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x    <= x_in;
        r_y    <= y_in;
        r_op   <= op_first;
        r_last <= w_eff_last;
      end
      if (r_state == ST_CAPTURE) begin
        r_res_data <= w_dz ? 8'h00 : alu_result;
        r_res_op   <= r_op;
        r_res_dz   <= w_dz;
      end
      if (w_handshake && !w_is_last) begin
        r_op <= r_op + 4'd1;
      end
    end
  end

`ifdef ALU_SWEEP_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= 8'h00;
    end else if (w_accept) begin
      r_checksum <= 8'h00;
    end else if (w_handshake) begin
      r_checksum <= r_checksum ^ r_res_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 8'h00;
`endif

  assign alu_x     = r_x;
  assign alu_y     = r_y;
  assign alu_op    = {4'h0, r_op};
  assign res_valid = (r_state == ST_PRESENT);
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;
  assign res_dz    = r_res_dz;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: a behavioural 4-bit ALU drives alu_result, a
// monitor collects delivered results, directed vectors come from a table and
// random sweeps are compared against a list-building reference model.
module tb_alu_sweep_driver;

  localparam int SETTLE = 2;
  localparam int OPMAX  = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] x_in = 4'd0;
  logic [3:0] y_in = 4'd0;
  logic [3:0] op_first = 4'd0;
  logic [3:0] op_last = 4'd0;
  logic [7:0] alu_result;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic [7:0] alu_op;
  logic       res_valid;
  logic       out_ready = 1'b0;
  logic [7:0] res_data;
  logic [3:0] res_op;
  logic       res_dz;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  alu_sweep_driver #(
    .SETTLE_CYCLES (SETTLE),
    .OP_MAX        (OPMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .op_first   (op_first),
    .op_last    (op_last),
    .alu_result (alu_result),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_op     (alu_op),
    .res_valid  (res_valid),
    .out_ready  (out_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .res_dz     (res_dz),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  // Behavioural ALU; a zero divisor returns a non-zero marker so that the
  // driver's forcing to 8'h00 is visible.
  function automatic logic [7:0] alu_fn(input logic [3:0] x, input logic [3:0] y, input logic [3:0] op);
    logic [7:0] xe;
    logic [7:0] ye;
    xe = {4'h0, x};
    ye = {4'h0, y};
    case (op)
      4'd0:    return xe + ye;
      4'd1:    return xe - ye;
      4'd2:    return xe * ye;
      4'd3:    return (y == 4'd0) ? 8'hEE : xe / ye;
      4'd4:    return xe & ye;
      4'd5:    return xe | ye;
      4'd6:    return xe ^ ye;
      4'd7:    return {4'h0, ~(x & y)};
      4'd8:    return {4'h0, ~(x | y)};
      4'd9:    return {4'h0, ~x};
      4'd10:   return (y == 4'd0) ? 8'hEE : xe % ye;
      4'd11:   return xe << y;
      4'd12:   return xe >> y;
      default: return 8'hAA;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_x, alu_y, alu_op[3:0]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: results accepted at the next edge, done pulses, and hold of
  // the offered result while the consumer stalls.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [12:0] prev_res = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (res_valid && prev_valid && !prev_ready) begin
        check("hold_while_stalled", {19'd0, res_op, res_data, res_dz}, {19'd0, prev_res});
      end
      if (res_valid && out_ready) got_q.push_back({res_op, res_data, res_dz});
      if (done) done_cnt <= done_cnt + 1;
      prev_valid <= res_valid;
      prev_ready <= out_ready;
      prev_res   <= {res_op, res_data, res_dz};
    end
  end

  // Reference model: the list of results a sweep must deliver.
  task automatic build_exp(input logic [3:0] x, input logic [3:0] y, input logic [3:0] f, input logic [3:0] l);
    int eff;
    exp_q.delete();
    eff = (int'(l) > OPMAX) ? OPMAX : int'(l);
    for (int op = int'(f); op <= eff; op++) begin
      if ((op == 3 || op == 10) && y == 4'd0) exp_q.push_back({4'(op), 8'h00, 1'b1});
      else exp_q.push_back({4'(op), alu_fn(x, y, 4'(op)), 1'b0});
    end
  endtask

  // Runs one sweep against exp_q. mode: 0 ready high, 1 stall 5 cycles per
  // result, 2 random ready. poke: raise start mid-sweep and on the done cycle.
  task automatic run_sweep(input logic [3:0] x, input logic [3:0] y, input logic [3:0] f,
                           input logic [3:0] l, input int mode, input bit poke, input string tag);
    int first_lat;
    int done_k;
    int stall;
    int dc0;
    int eff;
    int fin_op;
    int n;
    bit got;
    logic [7:0] cks;
    logic [7:0] exp_cks;
    logic [3:0] ax;
    logic [3:0] ay;
    logic [7:0] aop;
    got_q.delete();
    dc0 = done_cnt;
    first_lat = -1;
    done_k = -1;
    stall = 0;
    got = 1'b0;
    cks = 8'h00;
    ax = 4'd0;
    ay = 4'd0;
    aop = 8'd0;
    @(posedge clk); #1;
    x_in = x; y_in = y; op_first = f; op_last = l; start = 1'b1;
    out_ready = (mode == 0);
    for (int k = 1; k <= 3000 && !got; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      x_in = 4'($urandom); y_in = 4'($urandom);
      op_first = 4'($urandom); op_last = 4'($urandom);
      if (res_valid && first_lat < 0) first_lat = k;
      if (done) begin
        got = 1'b1; done_k = k;
        cks = checksum; ax = alu_x; ay = alu_y; aop = alu_op;
      end else begin
        case (mode)
          0: out_ready = 1'b1;
          1: begin
            if (res_valid) begin
              if (stall < 5) begin out_ready = 1'b0; stall++; end
              else out_ready = 1'b1;
            end else begin
              out_ready = 1'b0; stall = 0;
            end
          end
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (poke && k == 2) begin
          start = 1'b1; x_in = 4'd15; y_in = 4'd15; op_first = 4'd0; op_last = 4'd0;
        end
      end
    end
    if (!got) check({tag, ".done_timeout"}, 32'd0, 32'd1);
    // start on the FINISH->IDLE edge must be ignored
    start = poke;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".idle_after_done"}, {31'd0, busy}, 32'd0);

    n = exp_q.size();
    check({tag, ".n_results"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check($sformatf("%s.result%0d", tag, i), {19'd0, got_q[i]}, {19'd0, exp_q[i]});
    end
    check({tag, ".done_pulses"}, done_cnt - dc0, 32'd1);
    check({tag, ".first_valid_latency"}, first_lat, (n > 0) ? SETTLE + 2 : -1);
    if (mode == 0 || n == 0) check({tag, ".done_cycle"}, done_k, n * (SETTLE + 2) + 1);
    exp_cks = 8'h00;
`ifdef ALU_SWEEP_CHECKSUM_EN
    for (int i = 0; i < n; i++) exp_cks = exp_cks ^ exp_q[i][8:1];
`endif
    check({tag, ".checksum"}, {24'd0, cks}, {24'd0, exp_cks});
    eff = (int'(l) > OPMAX) ? OPMAX : int'(l);
    fin_op = (n > 0) ? eff : int'(f);
    check({tag, ".alu_x_held"}, {28'd0, ax}, {28'd0, x});
    check({tag, ".alu_y_held"}, {28'd0, ay}, {28'd0, y});
    check({tag, ".alu_op_held"}, {24'd0, aop}, fin_op);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".done"}, {31'd0, done}, 32'd0);
    check({tag, ".res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, ".res_data"}, {24'd0, res_data}, 32'd0);
    check({tag, ".res_op"}, {28'd0, res_op}, 32'd0);
    check({tag, ".res_dz"}, {31'd0, res_dz}, 32'd0);
    check({tag, ".alu_xy"}, {24'd0, alu_x, alu_y}, 32'd0);
    check({tag, ".alu_op"}, {24'd0, alu_op}, 32'd0);
    check({tag, ".checksum"}, {24'd0, checksum}, 32'd0);
  endtask

  typedef struct packed {
    logic [3:0]       x;
    logic [3:0]       y;
    logic [3:0]       f;
    logic [3:0]       l;
    logic [1:0]       mode;
    logic [1:0]       n;
    logic [2:0][3:0]  op;
    logic [2:0][7:0]  data;
    logic [2:0]       dz;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int k;
    int dc;
    logic [3:0] rx, ry, rf, rl;

    // op[i]/data[i]/dz[i] indexed from 0 = first delivered result
    tbl[0] = '{x: 4'd5, y: 4'd3, f: 4'd0,  l: 4'd2,  mode: 2'd0, n: 2'd3,
               op: {4'd2, 4'd1, 4'd0}, data: {8'h0F, 8'h02, 8'h08}, dz: 3'b000};
    tbl[1] = '{x: 4'd6, y: 4'd0, f: 4'd3,  l: 4'd3,  mode: 2'd0, n: 2'd1,
               op: {4'd0, 4'd0, 4'd3}, data: {8'h00, 8'h00, 8'h00}, dz: 3'b001};
    tbl[2] = '{x: 4'd9, y: 4'd4, f: 4'd4,  l: 4'd6,  mode: 2'd1, n: 2'd3,
               op: {4'd6, 4'd5, 4'd4}, data: {8'h0D, 8'h0D, 8'h00}, dz: 3'b000};
    tbl[3] = '{x: 4'd1, y: 4'd2, f: 4'd11, l: 4'd15, mode: 2'd0, n: 2'd2,
               op: {4'd0, 4'd12, 4'd11}, data: {8'h00, 8'h00, 8'h04}, dz: 3'b000};
    tbl[4] = '{x: 4'd5, y: 4'd3, f: 4'd5,  l: 4'd2,  mode: 2'd0, n: 2'd0,
               op: '0, data: '0, dz: 3'b000};

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      exp_q.delete();
      for (int j = 0; j < int'(tbl[i].n); j++) begin
        exp_q.push_back({tbl[i].op[j], tbl[i].data[j], tbl[i].dz[j]});
      end
      run_sweep(tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].l, int'(tbl[i].mode),
                (i == 0 || i == 3), $sformatf("vec%0d", i));
    end

    // Reset while a result waits in PRESENT: everything clears at once.
    @(posedge clk); #1;
    x_in = 4'd5; y_in = 4'd3; op_first = 4'd0; op_last = 4'd2; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!res_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("rst_mid.reached_present", {31'd0, res_valid}, 32'd1);
    dc = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid.no_done", done_cnt, dc);
    check("rst_mid.idle", {31'd0, busy}, 32'd0);

    build_exp(4'd5, 4'd3, 4'd0, 4'd2);
    run_sweep(4'd5, 4'd3, 4'd0, 4'd2, 0, 1'b1, "after_rst");

    // Random sweeps against the reference model.
    for (int i = 0; i < 25; i++) begin
      rx = 4'($urandom);
      ry = (i % 4 == 0) ? 4'd0 : 4'($urandom);
      rf = 4'($urandom_range(0, 13));
      rl = 4'($urandom_range(0, 15));
      build_exp(rx, ry, rf, rl);
      run_sweep(rx, ry, rf, rl, (i % 3 == 0) ? 0 : 2, (i % 5 == 0), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
